alu_decoder: RTL and testbench
==============================

# alu_decoder

Registered ALU control decoder for the single-cycle RV32I core. Maps the main decoder's 2-bit `ALUOp` plus instruction fields `funct3`, `funct7b5` and `opb5` onto a 4-bit `ALUControl` code for the ALU. The output is registered: each code appears one `clk` edge after its inputs are sampled.

## Interface
Parameters:
- none

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `ALUOp`  input  2  operation class from main decoder (00 load/store/add, 01 branch/sub, 10 R/I-type ALU, 11 unused)
- `funct3`  input  3  instruction bits [14:12]
- `funct7b5`  input  1  instruction bit 30
- `opb5`  input  1  opcode bit 5 (1 = R-type, 0 = I-type)
- `ALUControl`  output  4  registered ALU operation code
- `illegal`  output  1  registered decode-error flag; present only when `ALU_DECODER_ILLEGAL_EN` is defined

## Operation
- The next-state code is a pure combinational function of (`ALUOp`, `funct3`, `funct7b5`, `opb5`).
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110, SLT 0111, SLTU 1000, SLL 1010, SRL 1011, SRA 1100, NONE 1111.
- `ALUOp` = 00 → ADD. All other inputs are ignored.
- `ALUOp` = 01 → SUB. All other inputs are ignored.
- `ALUOp` = 10 decodes on `funct3`:
  - 000 → SUB if `funct7b5` & `opb5`, else ADD. `addi` never subtracts, whatever bit 30 holds.
  - 001 → SLL.
  - 010 → SLT.
  - 011 → SLTU.
  - 100 → XOR.
  - 101 → SRA if `funct7b5`, else SRL. `opb5` is ignored, so `srai`/`srli` decode the same as `sra`/`srl`.
  - 110 → OR.
  - 111 → AND.
- `ALUOp` = 11 → NONE (1111).
- X/Z on any input must not latch a stale value. The decode uses a full case with a default of 1111.

## Timing
- `ALUControl` (and `illegal`) update only on the rising edge of `clk`.
- Latency is exactly 1 cycle: the code valid after edge N reflects the inputs sampled at edge N.
- Reset is checked on the `clk` edge: when `reset` = 1, `ALUControl` ← 1111 and `illegal` ← 0, whatever the inputs are.
- Reset takes priority over decode.
- On the first edge with `reset` = 0, the current inputs are decoded normally. There is no extra recovery cycle.
- No handshake and no internal state beyond the output register(s).
- When inputs change every cycle, the output follows every change with one-cycle lag. No change is dropped.

## Configuration
- Macro: `ALU_DECODER_ILLEGAL_EN`.
- Defined: the `illegal` output port exists.
  - It is registered, with the same latency and reset behaviour as `ALUControl`.
  - It is 1 when `ALUOp` = 11.
  - It is also 1 when `ALUOp` = 10, `opb5` = 1 and `funct7b5` = 1 with `funct3` not in {000, 101} (an R-type encoding that is not RV32I).
  - It is 0 in every other case.
  - `ALUControl` is unaffected by this flag.
- Undefined: the `illegal` port and its logic are absent. `ALUControl` behaviour is identical.

## Test plan
- Assert `reset` for 2 edges with `ALUOp` = 10, `funct3` = 000 → `ALUControl` = 1111 after each edge. Release `reset` → 0010 after the next edge.
- `ALUOp` = 00, all fields 0 → 0010. Switch to `ALUOp` = 01 → 0110 one edge later. The output holds 0010 until that edge.
- `ALUOp` = 10, `funct7b5` = 1, `opb5` = 1, sweep `funct3` 000…111 one per cycle → 0110, 1010, 0111, 1000, 0100, 1100, 0001, 0000, each one edge after its input.
- `ALUOp` = 10, `funct3` = 000: `funct7b5` = 1, `opb5` = 0 → 0010; then `funct3` = 101, `funct7b5` = 0 → 1011; then `funct7b5` = 1, `opb5` = 0 → 1100.
- `ALUOp` = 11 with random fields → 1111. With `ALU_DECODER_ILLEGAL_EN` defined → `illegal` = 1.
  - Also with the macro: `ALUOp` = 10, `opb5` = 1, `funct7b5` = 1, `funct3` = 100 → `illegal` = 1 and `ALUControl` = 0100.
- Assert `reset` mid-sweep while `ALUOp` = 10, `funct3` = 111 → 1111 on that edge. Deassert → 0000 on the following edge.

Source files
------------

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//
// Registered ALU control decoder for the single-cycle RV32I core. It turns the
// main decoder's operation class plus the relevant instruction fields into the
// 4-bit ALU operation code. The code is registered, so it appears one clock
// edge after its inputs are sampled.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-high reset (output <- NONE)
//   ALUOp       in   2  00 add, 01 sub, 10 R/I-type ALU, 11 unused
//   funct3      in   3  instruction bits [14:12]
//   funct7b5    in   1  instruction bit 30
//   opb5        in   1  opcode bit 5 (1 = R-type, 0 = I-type)
//   ALUControl  out  4  registered ALU operation code
//   illegal     out  1  registered decode-error flag (only when the
//                       ALU_DECODER_ILLEGAL_EN macro is defined)
//
// Configuration macro: ALU_DECODER_ILLEGAL_EN
//   Defined   -> the illegal output and its decode logic exist.
//   Undefined -> no illegal port; ALUControl behaves identically.
// -----------------------------------------------------------------------------
module alu_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
`ifdef ALU_DECODER_ILLEGAL_EN
    output logic       illegal,
`endif
    output logic [3:0] ALUControl
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    logic [3:0] code_next;

    // Full case with NONE as the default so that X/Z on the selectors
    // produces a defined code instead of holding a stale one.
    always_comb begin
        code_next = ALU_NONE;
        case (ALUOp)
            2'b00: code_next = ALU_ADD;
            2'b01: code_next = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // Only R-type sub subtracts; addi ignores bit 30.
                    3'b000:  code_next = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code_next = ALU_SLL;
                    3'b010:  code_next = ALU_SLT;
                    3'b011:  code_next = ALU_SLTU;
                    3'b100:  code_next = ALU_XOR;
                    // Shift type comes from bit 30 for both srl/sra and srli/srai.
                    3'b101:  code_next = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code_next = ALU_OR;
                    3'b111:  code_next = ALU_AND;
                    default: code_next = ALU_NONE;
                endcase
            end
            default: code_next = ALU_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUControl <= ALU_NONE;
        end else begin
            ALUControl <= code_next;
        end
    end

`ifdef ALU_DECODER_ILLEGAL_EN
    logic illegal_next;

    // Flags the unused class and R-type encodings with bit 30 set on
    // funct3 values where RV32I defines no alternate operation.
    always_comb begin
        illegal_next = 1'b0;
        case (ALUOp)
            2'b11: illegal_next = 1'b1;
            2'b10: begin
                if (opb5 && funct7b5) begin
                    case (funct3)
                        3'b000, 3'b101: illegal_next = 1'b0;
                        default:        illegal_next = 1'b1;
                    endcase
                end
            end
            default: illegal_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= illegal_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_decoder
//
// Scoreboard bench for alu_decoder. The stimulus process drives inputs on the
// falling edge and pushes the expected registered response; a separate
// monitor pops and compares one entry after every rising edge. Expected codes
// come from an instruction-mnemonic reference model.
// -----------------------------------------------------------------------------
module tb_alu_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       opb5;
    logic [3:0] ALUControl;
`ifdef ALU_DECODER_ILLEGAL_EN
    logic       illegal;
`endif

    alu_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (opb5),
`ifdef ALU_DECODER_ILLEGAL_EN
        .illegal    (illegal),
`endif
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic       ill;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    // Reference model: name the operation the instruction asks for, then
    // look up that operation's ALU code.
    function automatic string op_name(input logic [1:0] op, input logic [2:0] f3,
                                      input logic f7, input logic ob5);
        string base [8];
        base = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        if (op == 2'd0) return "ADD";
        if (op == 2'd1) return "SUB";
        if (op == 2'd3) return "NONE";
        if (f3 == 3'd0 && f7 && ob5) return "SUB";
        if (f3 == 3'd5 && f7) return "SRA";
        return base[f3];
    endfunction

    function automatic logic [3:0] code_of(input string n);
        if (n == "AND")  return 4'd0;
        if (n == "OR")   return 4'd1;
        if (n == "ADD")  return 4'd2;
        if (n == "XOR")  return 4'd4;
        if (n == "SUB")  return 4'd6;
        if (n == "SLT")  return 4'd7;
        if (n == "SLTU") return 4'd8;
        if (n == "SLL")  return 4'd10;
        if (n == "SRL")  return 4'd11;
        if (n == "SRA")  return 4'd12;
        return 4'd15;
    endfunction

    function automatic logic is_illegal(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7, input logic ob5);
        if (op == 2'd3) return 1'b1;
        return (op == 2'd2) && ob5 && f7 && !(f3 == 3'd0 || f3 == 3'd5);
    endfunction

    task automatic drive(input logic r, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic ob5);
        exp_t e;
        @(negedge clk);
        reset    = r;
        ALUOp    = op;
        funct3   = f3;
        funct7b5 = f7;
        opb5     = ob5;
        if (r) begin
            e.name = "RESET";
            e.code = 4'hF;
            e.ill  = 1'b0;
        end else begin
            e.name = op_name(op, f3, f7, ob5);
            e.code = code_of(e.name);
            e.ill  = is_illegal(op, f3, f7, ob5);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: the output is meaningful after every rising edge that follows
    // a driven input set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ALUControl !== e.code) begin
                    errors++;
                    $display("FAIL alu_control op=%s got=%b want=%b", e.name, ALUControl, e.code);
                end else begin
                    $display("ok   alu_control op=%s code=%b", e.name, ALUControl);
                end
`ifdef ALU_DECODER_ILLEGAL_EN
                checks++;
                if (illegal !== e.ill) begin
                    errors++;
                    $display("FAIL illegal op=%s got=%b want=%b", e.name, illegal, e.ill);
                end
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; ALUOp = 2'd2; funct3 = 3'd0; funct7b5 = 1'b0; opb5 = 1'b0;

        // Reset held two edges, then released with add decoding.
        drive(1, 2'd2, 3'd0, 0, 0);
        drive(1, 2'd2, 3'd0, 0, 0);
        drive(0, 2'd2, 3'd0, 0, 0);

        // Load/store add then branch sub; output holds until the edge.
        drive(0, 2'd0, 3'd0, 0, 0);
        drive(0, 2'd0, 3'd0, 0, 0);
        drive(0, 2'd1, 3'd0, 0, 0);

        // R-type sweep with bit 30 set.
        for (int i = 0; i < 8; i++) drive(0, 2'd2, 3'(i), 1, 1);

        // addi with bit 30 set, srli, srai.
        drive(0, 2'd2, 3'd0, 1, 0);
        drive(0, 2'd2, 3'd5, 0, 0);
        drive(0, 2'd2, 3'd5, 1, 0);

        // Unused class with random fields; non-RV32I R-type xor.
        for (int i = 0; i < 4; i++)
            drive(0, 2'd3, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        drive(0, 2'd2, 3'd4, 1, 1);

        // Reset mid-sweep, then immediate recovery.
        for (int i = 0; i < 7; i++) drive(0, 2'd2, 3'(i), 0, 1);
        drive(1, 2'd2, 3'd7, 0, 1);
        drive(0, 2'd2, 3'd7, 0, 1);

        // Randomised traffic, inputs changing every cycle.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout got=running want=finished");
            $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
            $fatal(1, "timeout");
        end
    end

endmodule
